// File: rtl/ex_div_seq_if.sv
// Handshake and operand bundle between the EX stage and the iterative divider.
interface ex_div_seq_if;
    localparam int unsigned XLEN = 32;

    logic              start_ex;
    logic [1:0]        div_op_ex;
    logic [XLEN-1:0]   rs1_sel;
    logic [XLEN-1:0]   rs2_sel;
    logic              hold_ex;
    logic              abort;
    logic              div_stall;
    logic              div_done;
    logic [XLEN-1:0]   div_result;

    modport master (
        output start_ex, div_op_ex, rs1_sel, rs2_sel, hold_ex, abort,
        input  div_stall, div_done, div_result
    );

    modport slave (
        input  start_ex, div_op_ex, rs1_sel, rs2_sel, hold_ex, abort,
        output div_stall, div_done, div_result
    );
endinterface

// File: rtl/ex_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring shift-subtract, one quotient bit
// per cycle, stalling EX while it iterates and presenting a one-cycle result.
module ex_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    ex_div_seq_if.slave div_if
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              is_rem_q, is_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              stall_c;
    logic              is_signed_c;
    logic [XLEN-1:0]   mag_a_c, mag_b_c;
    logic [XLEN:0]     trial_c;
    logic              q_bit_c;
    logic [XLEN-1:0]   rem_nx_c, quo_nx_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
        end
    end

    // Next-state, iteration step and stall request
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        stall_c   = 1'b0;

        is_signed_c = ~div_if.div_op_ex[0];
        mag_a_c = (is_signed_c && div_if.rs1_sel[XLEN-1]) ? XLEN'(-div_if.rs1_sel) : div_if.rs1_sel;
        mag_b_c = (is_signed_c && div_if.rs2_sel[XLEN-1]) ? XLEN'(-div_if.rs2_sel) : div_if.rs2_sel;

        // Restoring step: the partial remainder never reaches the divisor, so the difference fits XLEN bits
        trial_c  = {rem_q, quo_q[XLEN-1]};
        q_bit_c  = (trial_c >= {1'b0, dvs_q});
        rem_nx_c = q_bit_c ? XLEN'(trial_c - {1'b0, dvs_q}) : trial_c[XLEN-1:0];
        quo_nx_c = {quo_q[XLEN-2:0], q_bit_c};

        case (state_q)
            S_IDLE: begin
                if (div_if.start_ex && !div_if.abort) begin
                    stall_c   = 1'b1;
                    is_rem_d  = div_if.div_op_ex[1];
                    neg_quo_d = is_signed_c & (div_if.rs1_sel[XLEN-1] ^ div_if.rs2_sel[XLEN-1]);
                    neg_rem_d = is_signed_c & div_if.rs1_sel[XLEN-1];
                    dvs_d     = mag_b_c;
                    quo_d     = mag_a_c;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (div_if.rs2_sel == '0) begin
                        result_d = div_if.div_op_ex[1] ? div_if.rs1_sel : '1;
                        state_d  = S_DONE;
                    end else if (is_signed_c && (div_if.rs1_sel == 32'h8000_0000) &&
                                 (div_if.rs2_sel == 32'hFFFF_FFFF)) begin
                        result_d = div_if.div_op_ex[1] ? '0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall_c = 1'b1;
                rem_d   = rem_nx_c;
                quo_d   = quo_nx_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_DONE;
                    if (is_rem_q) result_d = neg_rem_q ? XLEN'(-rem_nx_c) : rem_nx_c;
                    else          result_d = neg_quo_q ? XLEN'(-quo_nx_c) : quo_nx_c;
                end
            end
            S_DONE: begin
                if (!div_if.hold_ex) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                result_d = '0;
            end
        endcase

        // Flush wins over everything, including a start in the same cycle
        if (div_if.abort) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    assign div_if.div_stall  = stall_c;
    assign div_if.div_done   = (state_q == S_DONE);
    assign div_if.div_result = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Bench for ex_div_seq: directed RV32M vectors plus randomized divides, checked
// every cycle against an arithmetic reference for stall/done/result.
module tb_ex_div_seq;
    logic clk;
    logic rst_n;

    ex_div_seq_if dif();

    ex_div_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en;
    logic        exp_stall;
    logic        exp_done;
    logic [31:0] exp_result;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference: RV32M division semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("div_stall",  32'(dif.div_stall), 32'(exp_stall));
            check("div_done",   32'(dif.div_done),  32'(exp_done));
            check("div_result", dif.div_result,     exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic d, input logic [31:0] r);
        exp_stall  = s;
        exp_done   = d;
        exp_result = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dif.start_ex = 1'b0;
            dif.hold_ex  = 1'b0;
            dif.abort    = 1'b0;
            set_exp(1'b0, 1'b0, 32'd0);
            tick();
        end
    endtask

    task automatic scramble_inputs();
        dif.start_ex  = 1'($urandom_range(0, 1));
        dif.div_op_ex = 2'($urandom);
        dif.rs1_sel   = $urandom;
        dif.rs2_sel   = $urandom;
    endtask

    // One divide from start to the cycle after its last DONE cycle begins
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int hold_n, input bit noise);
        logic [31:0] res;
        int calc_n;
        res    = ref_div(op, a, b);
        calc_n = is_special(op, a, b) ? 0 : 32;
        dif.start_ex  = 1'b1;
        dif.div_op_ex = op;
        dif.rs1_sel   = a;
        dif.rs2_sel   = b;
        dif.abort     = 1'b0;
        dif.hold_ex   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        set_exp(1'b1, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < calc_n; i++) begin
            if (noise) begin
                scramble_inputs();
                dif.hold_ex = 1'($urandom_range(0, 1));
            end else begin
                dif.start_ex = 1'b0;
                dif.hold_ex  = 1'b0;
            end
            set_exp(1'b1, 1'b0, 32'd0);
            tick();
        end
        for (int j = 0; j <= hold_n; j++) begin
            if (noise) scramble_inputs();
            else       dif.start_ex = 1'b0;
            dif.hold_ex = (j < hold_n);
            set_exp(1'b0, 1'b1, res);
            tick();
        end
    endtask

    task automatic run_abort(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        dif.start_ex  = 1'b1;
        dif.div_op_ex = op;
        dif.rs1_sel   = a;
        dif.rs2_sel   = b;
        dif.hold_ex   = 1'b0;
        dif.abort     = 1'b0;
        set_exp(1'b1, 1'b0, 32'd0);
        tick();
        for (int i = 1; i < k; i++) begin
            dif.start_ex = 1'b0;
            set_exp(1'b1, 1'b0, 32'd0);
            tick();
        end
        dif.abort = 1'b1;
        set_exp(1'b1, 1'b0, 32'd0);
        tick();
        dif.abort = 1'b0;
        set_exp(1'b0, 1'b0, 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        chk_en        = 1'b0;
        rst_n         = 1'b0;
        dif.start_ex  = 1'b0;
        dif.div_op_ex = 2'd0;
        dif.rs1_sel   = 32'd0;
        dif.rs2_sel   = 32'd0;
        dif.hold_ex   = 1'b0;
        dif.abort     = 1'b0;
        set_exp(1'b0, 1'b0, 32'd0);

        // Hand-computed values pin the reference model
        check("model_div_100_7",   ref_div(2'b00, 32'd100, 32'd7), 32'h0000_000E);
        check("model_rem_100_7",   ref_div(2'b10, 32'd100, 32'd7), 32'h0000_0002);
        check("model_div_m7_2",    ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem_m7_2",    ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_divu_max_1",  ref_div(2'b01, 32'hFFFF_FFFF, 32'd1), 32'hFFFF_FFFF);
        check("model_remu_max_16", ref_div(2'b11, 32'hFFFF_FFFF, 32'h10), 32'h0000_000F);
        check("model_div_by_0",    ref_div(2'b00, 32'h1234, 32'd0), 32'hFFFF_FFFF);
        check("model_remu_by_0",   ref_div(2'b11, 32'h1234, 32'd0), 32'h0000_1234);
        check("model_div_ovf",     ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_rem_ovf",     ref_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        #12;
        check("reset_stall",  32'(dif.div_stall), 32'd0);
        check("reset_done",   32'(dif.div_done),  32'd0);
        check("reset_result", dif.div_result,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        idle(2);

        // Directed vectors; the first two are back-to-back
        run_div(2'b00, 32'd100, 32'd7, 0, 1'b0);
        run_div(2'b10, 32'd100, 32'd7, 0, 1'b0);
        idle(1);
        run_div(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
        run_div(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
        run_div(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_div(2'b11, 32'hFFFF_FFFF, 32'h10, 0, 1'b0);
        run_div(2'b00, 32'h1234, 32'd0, 0, 1'b0);
        run_div(2'b11, 32'h1234, 32'd0, 0, 1'b0);
        run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        idle(1);

        // Abort at T10, fresh divide starting at T12
        run_abort(2'b00, 32'd100, 32'd7, 10);
        run_div(2'b01, 32'd1000, 32'd33, 0, 1'b0);

        // Hold in DONE for three cycles
        run_div(2'b00, 32'hFFFF_FC18, 32'd9, 3, 1'b0);
        idle(1);

        // Abort beats start in the same cycle
        dif.start_ex  = 1'b1;
        dif.abort     = 1'b1;
        dif.div_op_ex = 2'b00;
        dif.rs1_sel   = 32'd50;
        dif.rs2_sel   = 32'd5;
        set_exp(1'b0, 1'b0, 32'd0);
        tick();
        idle(2);

        // Abort while held in DONE clears the result
        dif.start_ex  = 1'b1;
        dif.div_op_ex = 2'b00;
        dif.rs1_sel   = 32'h55;
        dif.rs2_sel   = 32'd0;
        set_exp(1'b1, 1'b0, 32'd0);
        tick();
        dif.start_ex = 1'b0;
        dif.hold_ex  = 1'b1;
        dif.abort    = 1'b1;
        set_exp(1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        idle(2);

        // Asynchronous reset in the middle of CALC
        dif.start_ex  = 1'b1;
        dif.div_op_ex = 2'b01;
        dif.rs1_sel   = 32'd12345;
        dif.rs2_sel   = 32'd67;
        set_exp(1'b1, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            dif.start_ex = 1'b0;
            set_exp(1'b1, 1'b0, 32'd0);
            tick();
        end
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall",  32'(dif.div_stall), 32'd0);
        check("async_rst_done",   32'(dif.div_done),  32'd0);
        check("async_rst_result", dif.div_result,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        idle(2);
        run_div(2'b00, 32'd100, 32'd7, 0, 1'b0);

        // Randomized divides, including edge operands and special cases
        for (int n = 0; n < 60; n++) begin
            r_op = 2'($urandom);
            r_a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 15));
                3:       r_b = 32'h8000_0000;
                default: r_b = $urandom;
            endcase
            run_div(r_op, r_a, r_b, $urandom_range(0, 2), 1'b1);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Iterative divide sequencer for the execute stage: implements RV32M DIV/DIVU/REM/REMU with a restoring shift-subtract datapath controlled by a small state machine. It sits beside the EX ALU. It takes the forwarded operands, stalls the pipeline while iterating, and presents a one-cycle result that EX muxes into its rd data path ahead of the EX→MA flops. Pipeline flush aborts it.

## Interface
Parameters: none (fixed 32-bit, 1 quotient bit per cycle).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- start_ex  in  1  divide instruction valid in EX (already qualified with ~jmp_purge_ma)
- div_op_ex  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_sel  in  32  dividend (post-forwarding)
- rs2_sel  in  32  divisor (post-forwarding)
- hold_ex  in  1  external pipeline hold (dc_stall / other stall) not caused by this block
- abort  in  1  rst_pipe / flush; kills operation
- div_stall  out  1  stall request to pipeline control
- div_done  out  1  result valid this cycle
- div_result  out  32  quotient or remainder per div_op

## Operation
- States: IDLE, CALC, DONE. Reset: IDLE, div_stall=0, div_done=0, div_result=0, all internal regs 0.
- IDLE:
  - start_ex=1 latches the operands, div_op and the sign flags. signed = ~div_op[0]. neg_q = signed & (rs1[31]^rs2[31]). neg_r = signed & rs1[31].
  - Magnitudes are |rs1| and |rs2| when signed, else the raw values.
- Special cases resolved in IDLE, next state DONE:
  - Divisor 0: Q=0xFFFFFFFF, R=rs1 (raw).
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): Q=0x80000000, R=0.
- Otherwise next state CALC with cnt=0, rem=0, quo=|dividend|.
- CALC, each cycle:
  - t = {rem[31:0], quo[31]} (33 bits). If t >= {1'b0,|divisor|}: rem=t-|divisor|, new quo bit=1. Else rem=t[31:0], bit=0.
  - quo = {quo[30:0], bit}. cnt++.
  - After the cycle with cnt=31, go to DONE.
- On DONE entry, the result register is loaded:
  - DIV/DIVU: neg_q ? -quo : quo.
  - REM/REMU: neg_r ? -rem : rem.
  - Special-case values are taken as-is, with no sign fix.
- DONE: div_done=1, div_result valid. If hold_ex=0, go to IDLE. If hold_ex=1, stay in DONE holding the result.
- start_ex is ignored in CALC and DONE. The EX instruction is the same one being divided.
- abort from any state: next state IDLE, div_done=0, result register cleared. abort beats start_ex in the same cycle.
- div_result=0 whenever div_done=0.

## Timing
- div_stall = (IDLE & start_ex & ~abort) | CALC. This is combinational in the start cycle so the EX→MA flops do not capture in that cycle.
- Normal latency: start cycle T0 (IDLE), CALC T1–T32, DONE T33.
  - div_stall is high T0–T32 and low at T33.
  - EX→MA captures div_result at the T33 edge (absent hold_ex).
- Special-case latency: T0 start (stall=1), T1 DONE (stall=0, done=1).
- Back-to-back divides: the second instruction reaches EX at T34 and is seen as start_ex in IDLE.
- hold_ex during CALC has no effect; iteration continues.
- abort asserted at cycle Tk: div_stall=0 at Tk+1, state IDLE.
- All state/result regs are posedge clk with async clear on rst_n low. Outputs go to reset values immediately on rst_n assert.

## Test plan
- DIV 100/7 → stall for T0–T32, done at T33 with 0x0000000E; REM same operands → 0x00000002.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 0xFFFFFFFF/0x10 → 0xF.
- Divide by zero: DIV 0x1234/0 → 0xFFFFFFFF, REMU 0x1234/0 → 0x1234, done at T1, stall only T0.
- Overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; latency 2 cycles.
- abort at T10 of a CALC: stall low at T11, no done pulse, next start_ex at T12 runs a fresh divide correctly.
- hold_ex=1 for 3 cycles entering DONE: done and result stable for 4 cycles, IDLE after hold_ex drops; rst_n low mid-CALC clears all outputs asynchronously.
